// File: rtl/spi_tx_sched_if.sv
// Bus between the SPI transmit scheduler, its upstream requesters and the shared transmitter.
// The scheduler uses the slave modport; the requesters and transmitter use master.
interface spi_tx_sched_if #(
    parameter int N_CH = 4,
    parameter int DW   = 24,
    parameter int GW   = 2
);
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*DW-1:0] req_data;
    logic [N_CH-1:0]    req_ready;
    logic [N_CH-1:0]    done;
    logic [DW-1:0]      BUS_DATA;
    logic               tx_valid;
    logic               spi_ready;
    logic               busy;
    logic [GW-1:0]      grant;

    modport slave (
        input  req_valid, req_data, spi_ready,
        output req_ready, done, BUS_DATA, tx_valid, busy, grant
    );

    modport master (
        output req_valid, req_data, spi_ready,
        input  req_ready, done, BUS_DATA, tx_valid, busy, grant
    );
endinterface

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler that shares one SPI transmitter among N_CH requesters.
// Build macro SPI_SCHED_PRIO_EN gives channel 0 strict priority over the round-robin group.
module spi_tx_sched #(
    parameter int N_CH = 4,
    parameter int DW   = 24,
    parameter int GW   = 2
) (
    input  logic           clk,
    input  logic           RSTn,
    spi_tx_sched_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BUSY} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt, winner, grant_q;
    logic            found, seen_low;
    logic [DW-1:0]   data_q;
    logic [N_CH-1:0] done_q, req_ready;
    logic            tx_valid;

    // Search from rr_ptr upward, wrapping, for the first requesting channel.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_CH; k++) begin
`ifdef SPI_SCHED_PRIO_EN
            if (!found && ((int'(rr_ptr) + k) % N_CH) != 0 &&
                bus.req_valid[(int'(rr_ptr) + k) % N_CH]) begin
`else
            if (!found && bus.req_valid[(int'(rr_ptr) + k) % N_CH]) begin
`endif
                found  = 1'b1;
                winner = GW'((int'(rr_ptr) + k) % N_CH);
            end
        end
`ifdef SPI_SCHED_PRIO_EN
        if (bus.req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
        // Channel 0 wins leave the pointer alone; the group 1..N_CH-1 wraps back to 1.
        if (winner == '0)
            rr_ptr_nxt = rr_ptr;
        else if (int'(winner) == N_CH - 1)
            rr_ptr_nxt = GW'(1);
        else
            rr_ptr_nxt = winner + GW'(1);
`else
        if (int'(winner) == N_CH - 1)
            rr_ptr_nxt = '0;
        else
            rr_ptr_nxt = winner + GW'(1);
`endif
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (bus.spi_ready)
                    state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                // The transmitter may still look idle for a cycle after the handshake.
                if (seen_low && bus.spi_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            grant_q  <= '0;
            rr_ptr   <= '0;
            seen_low <= 1'b0;
            done_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        data_q  <= bus.req_data[int'(winner) * DW +: DW];
                        grant_q <= winner;
                        rr_ptr  <= rr_ptr_nxt;
                    end
                end
                ST_SEND: begin
                    if (bus.spi_ready)
                        seen_low <= 1'b0;
                end
                ST_BUSY: begin
                    if (!bus.spi_ready)
                        seen_low <= 1'b1;
                    else if (seen_low)
                        done_q[grant_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_valid  = tx_valid;
    assign bus.BUS_DATA  = data_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_spi_tx_sched.sv
// Scoreboard bench for spi_tx_sched: requesters and a transmitter model drive the bus,
// a monitor pops expected accepts, transfers and done pulses as the DUT presents them.
module tb_spi_tx_sched;
    localparam int N_CH = 4;
    localparam int DW   = 24;
    localparam int GW   = 2;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } tx_t;

    logic clk;
    logic RSTn;

    spi_tx_sched_if #(.N_CH(N_CH), .DW(DW), .GW(GW)) bus ();

    spi_tx_sched #(.N_CH(N_CH), .DW(DW), .GW(GW)) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard queues
    int            acc_q[$];
    tx_t           tx_q[$];
    logic [N_CH-1:0] done_q[$];
    int            done_cyc_q[$];

    // Per-channel word queues feeding the requesters
    logic [DW-1:0] words [N_CH][16];
    int            head [N_CH];
    int            tail [N_CH];

    // Transmitter model knobs
    int pre_wait = 0;
    int lag      = 0;
    int xfer_len = 8;
    int exp_hold = 1;
    int epoch    = 0;
    bit model_idle = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event missing or unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [N_CH-1:0] onehot(input int ch);
        return N_CH'(1 << ch);
    endfunction

    task automatic push_word(input int ch, input logic [DW-1:0] data);
        words[ch][tail[ch] % 16] = data;
        tail[ch]++;
    endtask

    task automatic expect_tx(input int ch, input logic [DW-1:0] data);
        tx_t t;
        t.ch   = ch;
        t.data = data;
        acc_q.push_back(ch);
        tx_q.push_back(t);
        done_q.push_back(onehot(ch));
    endtask

    function automatic bit pending();
        return acc_q.size() != 0 || tx_q.size() != 0 || done_q.size() != 0 ||
               bus.busy || !model_idle;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (pending())
            fail(name);
    endtask

    // Requesters: present the head word of each channel until it is accepted.
    initial begin
        logic [N_CH-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            acc = RSTn ? (bus.req_ready & bus.req_valid) : '0;
            @(posedge clk);
            #1;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c])
                    head[c]++;
                if (head[c] < tail[c]) begin
                    bus.req_valid[c]            = 1'b1;
                    bus.req_data[c * DW +: DW]  = words[c][head[c] % 16];
                end else begin
                    bus.req_valid[c] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: optional busy-at-issue, optional ready lag, then a low period.
    initial begin
        int ep;
        bus.spi_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_valid && RSTn) begin
                model_idle = 1'b0;
                ep = epoch;
                if (pre_wait > 0) begin
                    bus.spi_ready = 1'b0;
                    repeat (pre_wait) @(negedge clk);
                    bus.spi_ready = 1'b1;
                end
                repeat (1 + lag) @(negedge clk);
                bus.spi_ready = 1'b0;
                repeat (xfer_len) @(negedge clk);
                bus.spi_ready = 1'b1;
                if (ep == epoch)
                    done_cyc_q.push_back(cyc + 1);
                model_idle = 1'b1;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard as they appear.
    initial begin
        bit            prev_tx = 1'b0;
        bit            unstable = 1'b0;
        int            acc_cyc = 0;
        int            tx_hi = 0;
        logic [DW-1:0] tx_word = '0;
        tx_t           t;
        forever begin
            @(negedge clk);
            #1;
            if (!RSTn) begin
                prev_tx = 1'b0;
            end else begin
                if (bus.req_ready != '0) begin
                    acc_cyc = cyc;
                    if (acc_q.size() == 0)
                        fail("req_ready_unexpected");
                    else
                        check("req_ready", 32'(bus.req_ready), 32'(onehot(acc_q.pop_front())));
                end
                if (bus.tx_valid) begin
                    if (!prev_tx) begin
                        check("tx_latency", 32'(cyc - acc_cyc), 32'd1);
                        tx_hi    = 0;
                        tx_word  = bus.BUS_DATA;
                        unstable = 1'b0;
                    end
                    tx_hi++;
                    if (bus.BUS_DATA !== tx_word)
                        unstable = 1'b1;
                    if (bus.spi_ready) begin
                        if (tx_q.size() == 0) begin
                            fail("handshake_unexpected");
                        end else begin
                            t = tx_q.pop_front();
                            check("grant", 32'(bus.grant), 32'(t.ch));
                            check("bus_data", 32'(bus.BUS_DATA), 32'(t.data));
                            check("tx_hold_cycles", 32'(tx_hi), 32'(exp_hold));
                            check("bus_data_stable", 32'(unstable), 32'd0);
                        end
                    end
                end
                prev_tx = bus.tx_valid;
                if (bus.done != '0) begin
                    if (done_q.size() == 0 || done_cyc_q.size() == 0) begin
                        fail("done_unexpected");
                    end else begin
                        check("done", 32'(bus.done), 32'(done_q.pop_front()));
                        check("done_cycle", 32'(cyc), 32'(done_cyc_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        RSTn = 1'b0;

        // Reset state, with all four channels already requesting.
        push_word(0, 24'h111111);
        push_word(0, 24'h100001);
        push_word(1, 24'h222222);
        push_word(2, 24'h333333);
        push_word(3, 24'h444444);
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_grant",    32'(bus.grant),    32'd0);
        check("rst_bus_data", 32'(bus.BUS_DATA), 32'd0);

`ifdef SPI_SCHED_PRIO_EN
        expect_tx(0, 24'h111111);
        expect_tx(0, 24'h100001);
        expect_tx(1, 24'h222222);
        expect_tx(2, 24'h333333);
        expect_tx(3, 24'h444444);
`else
        expect_tx(0, 24'h111111);
        expect_tx(1, 24'h222222);
        expect_tx(2, 24'h333333);
        expect_tx(3, 24'h444444);
        expect_tx(0, 24'h100001);
`endif
        @(negedge clk);
        RSTn = 1'b1;
        drain("drain_round_robin", 500);

        // Single request with a long transfer.
        xfer_len = 600;
        push_word(2, 24'hA5C3F0);
        expect_tx(2, 24'hA5C3F0);
        drain("drain_single", 2000);
        check("grant_after_single", 32'(bus.grant), 32'd2);

        // Transmitter busy when the word is issued.
        xfer_len = 8;
        pre_wait = 5;
        exp_hold = 6;
        push_word(1, 24'hC0FFEE);
        expect_tx(1, 24'hC0FFEE);
        drain("drain_busy_at_issue", 200);
        pre_wait = 0;
        exp_hold = 1;

        // Ready stays high one cycle past the handshake.
        lag = 1;
        push_word(3, 24'h5A5A5A);
        expect_tx(3, 24'h5A5A5A);
        drain("drain_ready_lag", 200);
        lag = 0;

        // Reset in the middle of a transfer owned by channel 1.
        xfer_len = 40;
        push_word(1, 24'h777777);
        expect_tx(1, 24'h777777);
        n = 0;
        while (!(bus.busy && !bus.tx_valid && bus.grant == GW'(1)) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!(bus.busy && !bus.tx_valid && bus.grant == GW'(1)))
            fail("reach_busy_state");
        repeat (3) @(negedge clk);
        RSTn = 1'b0;
        epoch++;
        done_q.delete();  // the aborted transfer must not complete
        #1;
        check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_busy",     32'(bus.busy),     32'd0);
        check("midrst_done",     32'(bus.done),     32'd0);
        check("midrst_grant",    32'(bus.grant),    32'd0);
        check("midrst_bus_data", 32'(bus.BUS_DATA), 32'd0);
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        n = 0;
        while (!model_idle && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!model_idle)
            fail("model_idle_after_reset");
        xfer_len = 8;

        // Pointer restarts at 0: 4'b1010 serves 1 then 3; then 4'b0011 serves 0 then 1.
        push_word(1, 24'h0A0A0A);
        push_word(3, 24'h0B0B0B);
        expect_tx(1, 24'h0A0A0A);
        expect_tx(3, 24'h0B0B0B);
        drain("drain_after_reset_a", 300);
        push_word(0, 24'h0C0C0C);
        push_word(1, 24'h0D0D0D);
        expect_tx(0, 24'h0C0C0C);
        expect_tx(1, 24'h0D0D0D);
        drain("drain_after_reset_b", 300);

        // All channels pending with the pointer at 2, channel 1 holding two words.
        push_word(0, 24'h000AAA);
        push_word(1, 24'h111000);
        push_word(1, 24'h111001);
        push_word(2, 24'h222000);
        push_word(3, 24'h333000);
`ifdef SPI_SCHED_PRIO_EN
        expect_tx(0, 24'h000AAA);
        expect_tx(2, 24'h222000);
        expect_tx(3, 24'h333000);
        expect_tx(1, 24'h111000);
        expect_tx(1, 24'h111001);
`else
        expect_tx(2, 24'h222000);
        expect_tx(3, 24'h333000);
        expect_tx(0, 24'h000AAA);
        expect_tx(1, 24'h111000);
        expect_tx(1, 24'h111001);
`endif
        drain("drain_mixed", 600);

        repeat (5) @(negedge clk);
        check("leftover_entries", 32'(acc_q.size() + tx_q.size() + done_q.size() + done_cyc_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_tx_sched.md
Name: spi_tx_sched

Overview:
Round-robin scheduler that shares the single 24-bit SPI transmitter among N_CH requesters. It accepts one 24-bit word at a time from the winning channel and holds it. It then presents the word on the transmitter's valid/ready bus and tracks the transfer until the transmitter returns to idle. On completion it pulses a per-channel done flag. It sits between upstream command sources and the SPI transmitter, and is the only master of that transmitter's bus.

Parameters:
N_CH, 4, number of requesting channels (2..8)
DW, 24, word width; must match transmitter BUS_DATA width
GW, 2, grant index width, clog2(N_CH)

Ports:
clk  input  1  system clock
RSTn  input  1  asynchronous active-low reset
req_valid  input  N_CH  per-channel word valid
req_data  input  N_CH*DW  per-channel word; channel i occupies bits [i*DW +: DW]
req_ready  output  N_CH  one-hot accept strobe, combinational
done  output  N_CH  one-cycle pulse: channel's word fully shifted out
BUS_DATA  output  DW  word to transmitter, registered
tx_valid  output  1  transmit request to transmitter
spi_ready  input  1  transmitter idle/ready
busy  output  1  scheduler not in ST_IDLE
grant  output  GW  channel currently owning the transmitter, registered

Behaviour:
- Reset (async, RSTn low): state ST_IDLE; BUS_DATA=0, tx_valid=0, done=0, grant=0, rr_ptr=0, seen_low=0. req_ready=0 whenever not in ST_IDLE.
- Reset mid-transfer returns to ST_IDLE immediately. The held word is discarded and no done pulse is issued.
- Arbitration: combinational search from rr_ptr upward, wrapping modulo N_CH, for the first set req_valid bit.
- rr_ptr <= winner+1 (wrapping to 0 after N_CH-1) on each grant.
- FSM:
  - ST_IDLE: if any req_valid: req_ready[winner]=1 in the same cycle; BUS_DATA<=req_data[winner]; grant<=winner; next ST_SEND. Otherwise stay.
  - ST_SEND: tx_valid=1 and BUS_DATA held stable. If spi_ready=1 this cycle (handshake): tx_valid deasserts next cycle; seen_low<=0; next ST_BUSY. Otherwise hold tx_valid and stay.
  - ST_BUSY: seen_low<=1 when spi_ready=0. When seen_low=1 and spi_ready=1: done[grant]<=1 for exactly one cycle; next ST_IDLE.
  - spi_ready high in ST_BUSY before any low cycle is ignored. This covers the one-cycle lag between handshake and the transmitter leaving idle.
- tx_valid is asserted only in ST_SEND. tx_valid is never deasserted before the handshake.
- A new grant is allowed in the same cycle the done pulse is high.
- Latency:
  - req_valid rise in ST_IDLE -> req_ready the same cycle.
  - tx_valid is high the next cycle.
  - done asserts the cycle after spi_ready re-rises.
- req_valid on non-winning channels is held pending. The requester must keep valid and data stable until req_ready.
- Back-to-back requests from one channel are served only after every other pending channel has been served once (fairness bound N_CH-1 transfers).
- busy = (state != ST_IDLE). grant holds the last winner while idle.

Optional Feature:
SPI_SCHED_PRIO_EN
- Defined: channel 0 has strict priority. If req_valid[0] is set in ST_IDLE it wins regardless of rr_ptr, and rr_ptr is not updated. Channels 1..N_CH-1 round-robin among themselves when channel 0 is idle; their pointer wraps 1..N_CH-1.
- Undefined: pure round-robin over all channels as above.

Test Plan:
- Single request: req_valid=4'b0100, data 24'hA5C3F0, spi_ready=1 -> req_ready=4'b0100 in the same cycle; tx_valid and BUS_DATA=24'hA5C3F0 next cycle, handshake in that cycle. Model drops spi_ready for ~600 cycles then raises it -> done=4'b0100 for 1 cycle; grant=2.
- Round-robin: all four req_valid held high from reset -> grants in order 0,1,2,3,0. Exactly one done pulse per transfer, no overlap of tx_valid.
- Transmitter busy at issue: spi_ready=0 for 5 cycles after entry to ST_SEND -> tx_valid held 6 cycles with stable BUS_DATA; handshake on the first spi_ready=1 cycle.
- Ready-lag: spi_ready stays 1 for 1 cycle after the handshake, then drops -> no premature done; done only after spi_ready returns high.
- Reset mid-transfer: RSTn low during ST_BUSY with grant=1 -> tx_valid=0, busy=0, done=0, grant=0, rr_ptr=0 immediately. After release, req_valid=4'b0011 -> channel 0 wins.
- SPI_SCHED_PRIO_EN defined: req_valid=4'b1111 continuously -> channel 0 wins every arbitration. With req_valid=4'b1110 -> order 1,2,3,1.
